alu_share_ctrl: RTL

Sequencer and arbiter that shares the single 32-bit ALU between two requesters: port 0 is the main execute datapath and port 1 is the address/increment unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and control inputs from latched registers. It captures the result and flags, then holds the response until the owning requester consumes it. It also owns the architectural NZCV flag register and an operation counter.

---
 rtl/alu_share_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one DW-bit ALU between the execute datapath (port 0) and the address unit (port 1).
// Define ALU_SHARE_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module alu_share_ctrl #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [DW-1:0]    REQ0_X,
  input  logic [DW-1:0]    REQ0_Y,
  input  logic [3:0]       REQ0_CTRL,
  input  logic             REQ0_SETF,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [DW-1:0]    REQ1_X,
  input  logic [DW-1:0]    REQ1_Y,
  input  logic [3:0]       REQ1_CTRL,
  input  logic             REQ1_SETF,
  output logic             RSP0_VALID,
  input  logic             RSP0_READY,
  output logic             RSP1_VALID,
  input  logic             RSP1_READY,
  output logic [DW-1:0]    RSP_DATA,
  output logic [DW-1:0]    ALU_X,
  output logic [DW-1:0]    ALU_Y,
  output logic [3:0]       ALU_CTRL,
  input  logic [DW-1:0]    ALU_OUT,
  output logic [3:0]       FLAGS,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;

  state_t           state_q;
  logic             last_grant_q;
  logic             owner_q;
  logic             setf_q;
  logic [1:0]       op_q;
  logic [DW-1:0]    x_q;
  logic [DW-1:0]    y_q;
  logic [DW-1:0]    rsp_data_q;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;

  logic             grant0;
  logic             grant1;
  logic [DW:0]      sum_d;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] cnt_d;
  logic             owner_rsp_ready;
  logic             unused_inputs;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      grant0 = REQ0_VALID;
      grant1 = REQ1_VALID && !REQ0_VALID;
`else
      // With both valid, the port that did not win last time goes next.
      grant0 = REQ0_VALID && (!REQ1_VALID || last_grant_q);
      grant1 = REQ1_VALID && (!REQ0_VALID || !last_grant_q);
`endif
    end
  end

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;

  // Carry is taken from the latched operands, not from ALU_OUT.
  always_comb begin
    sum_d      = {1'b0, x_q} + {1'b0, y_q};
    flags_d    = flags_q;
    flags_d[3] = ALU_OUT[DW-1];
    flags_d[2] = (ALU_OUT == '0);
    if (op_q == OP_ADD) begin
      flags_d[1] = sum_d[DW];
      flags_d[0] = (x_q[DW-1] == y_q[DW-1]) && (ALU_OUT[DW-1] != x_q[DW-1]);
    end
  end

  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  assign owner_rsp_ready = owner_q ? RSP1_READY : RSP0_READY;

  assign unused_inputs = ^{REQ0_CTRL[3:2], REQ1_CTRL[3:2], sum_d[DW-1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      setf_q       <= 1'b0;
      op_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      rsp_data_q   <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 || grant1) begin
            owner_q      <= grant1;
            last_grant_q <= grant1;
            x_q          <= grant1 ? REQ1_X : REQ0_X;
            y_q          <= grant1 ? REQ1_Y : REQ0_Y;
            op_q         <= grant1 ? REQ1_CTRL[1:0] : REQ0_CTRL[1:0];
            setf_q       <= grant1 ? REQ1_SETF : REQ0_SETF;
            state_q      <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data_q   <= ALU_OUT;
          cnt_q        <= cnt_d;
          if (setf_q) flags_q <= flags_d;
          rsp0_valid_q <= !owner_q;
          rsp1_valid_q <= owner_q;
          state_q      <= S_DONE;
        end
        S_DONE: begin
          if (owner_rsp_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign RSP0_VALID = rsp0_valid_q;
  assign RSP1_VALID = rsp1_valid_q;
  assign RSP_DATA   = rsp_data_q;
  assign ALU_X      = x_q;
  assign ALU_Y      = y_q;
  assign ALU_CTRL   = {2'b00, op_q};
  assign FLAGS      = flags_q;
  assign BUSY       = (state_q != S_IDLE);
  assign OP_CNT     = cnt_q;

endmodule
